aes_byte_loader: RTL and testbench

Input-side feeder for the AES cipher/decipher cores. It accepts a byte stream over a valid/ready handshake and assembles the 128/192/256-bit key and the 128-bit data block in FIPS-197 byte order. It then launches the core with a one-cycle start pulse and holds its outputs stable until the core reports done. It replaces the hard-wired key and plaintext constants in the top level, so the board or UART front end can drive the cores.

---
 rtl/aes_byte_loader_pkg.sv | 35 +++
 rtl/aes_shift_accum.sv | 36 +++
 rtl/aes_byte_loader.sv | 175 +++++++++++++++++
 tb/tb_aes_byte_loader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/aes_byte_loader_pkg.sv
// Shared definitions for the AES byte loader: FSM state encoding, key-size
// mode codes, key/block byte lengths and a helper giving the index of the
// final byte of a key frame for a given mode.
package aes_byte_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_DATA,
    S_START,
    S_WAIT
  } state_t;

  localparam logic [1:0] MODE_128 = 2'b00;
  localparam logic [1:0] MODE_192 = 2'b01;
  localparam logic [1:0] MODE_256 = 2'b10;
  localparam logic [1:0] MODE_ILL = 2'b11;

  localparam int unsigned KEY_BYTES_128 = 16;
  localparam int unsigned KEY_BYTES_192 = 24;
  localparam int unsigned KEY_BYTES_256 = 32;
  localparam int unsigned AES_BLK_BYTES = 16;

  // Count value (bytes already received) at which the incoming byte is the
  // last one of a key frame.
  function automatic logic [5:0] key_last_idx(input logic [1:0] m);
    case (m)
      MODE_128: return 6'(KEY_BYTES_128 - 1);
      MODE_192: return 6'(KEY_BYTES_192 - 1);
      MODE_256: return 6'(KEY_BYTES_256 - 1);
      default:  return 6'(KEY_BYTES_128 - 1);
    endcase
  endfunction

endpackage

// File: rtl/aes_shift_accum.sv
// Width-W byte accumulator: each enabled cycle shifts din in at the LSB end,
// so the first byte of a frame ends up most significant.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear contents (combined with en, the new byte lands on zero)
//   en         : shift din in this cycle
//   din[7:0]   : byte to shift in
//   q[W-1:0]   : accumulated value
module aes_shift_accum #(
  parameter int unsigned W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [7:0]   din,
  output logic [W-1:0] q
);

  logic [W-1:0] base;

  always_comb begin
    base = clr ? '0 : q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= {base[W-9:0], din};
    end else if (clr) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/aes_byte_loader.sv
// AES input feeder: assembles a key (128/192/256 bit) and a 128-bit data
// block from a valid/ready byte stream, launches the core with a one-cycle
// start pulse and holds key/block until the core reports done.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   in_valid/in_data    : byte stream input
//   in_ready            : loader accepts a byte this cycle
//   load_key, mode      : frame type and key size, sampled on a frame's first byte
//   core_done           : completion pulse from the cipher core
//   key_out/key_mode    : assembled key (right-aligned) and its size code
//   key_valid           : a complete key is held
//   block_out           : assembled data block, first byte most significant
//   start, busy, error  : launch pulse, in-flight indicator, protocol error pulse
module aes_byte_loader
  import aes_byte_loader_pkg::*;
#(
  parameter int unsigned KEY_W     = 256,
  parameter int unsigned BLK_BYTES = AES_BLK_BYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  input  logic                   load_key,
  input  logic [1:0]             mode,
  input  logic                   core_done,
  output logic [KEY_W-1:0]       key_out,
  output logic [1:0]             key_mode,
  output logic                   key_valid,
  output logic [8*BLK_BYTES-1:0] block_out,
  output logic                   start,
  output logic                   busy,
  output logic                   error
);

  localparam logic [5:0] BLK_LAST = 6'(BLK_BYTES - 1);

  state_t     state, state_nxt;
  logic [5:0] count, count_nxt;
  logic       ready_q;
  logic       accept;
  logic       key_clr, key_en, blk_en;
  logic       kv_set, kv_clr, mode_ld, err_set;

  assign accept = in_valid && ready_q;

  aes_shift_accum #(.W(KEY_W)) u_key_accum (
    .clk   (clk),
    .rst_n (reset),
    .clr   (key_clr),
    .en    (key_en),
    .din   (in_data),
    .q     (key_out)
  );

  aes_shift_accum #(.W(8*BLK_BYTES)) u_blk_accum (
    .clk   (clk),
    .rst_n (reset),
    .clr   (1'b0),
    .en    (blk_en),
    .din   (in_data),
    .q     (block_out)
  );

  // State register plus the small amount of registered side state.
  // in_ready is registered from the next state so it is 0 while in reset
  // yet still tracks the state exactly once running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      count     <= '0;
      key_mode  <= '0;
      key_valid <= 1'b0;
      error     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      error   <= err_set;
      ready_q <= (state_nxt == S_IDLE) || (state_nxt == S_KEY) || (state_nxt == S_DATA);
      if (mode_ld) begin
        key_mode <= mode;
      end
      if (kv_clr) begin
        key_valid <= 1'b0;
      end else if (kv_set) begin
        key_valid <= 1'b1;
      end
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    key_clr   = 1'b0;
    key_en    = 1'b0;
    blk_en    = 1'b0;
    kv_set    = 1'b0;
    kv_clr    = 1'b0;
    mode_ld   = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (load_key) begin
            if (mode == MODE_ILL) begin
              err_set = 1'b1;
            end else begin
              key_clr   = 1'b1;
              key_en    = 1'b1;
              kv_clr    = 1'b1;
              mode_ld   = 1'b1;
              count_nxt = 6'd1;
              state_nxt = S_KEY;
            end
          end else begin
            blk_en    = 1'b1;
            count_nxt = 6'd1;
            state_nxt = S_DATA;
          end
        end
      end
      S_KEY: begin
        if (accept) begin
          key_en = 1'b1;
          if (count == key_last_idx(key_mode)) begin
            count_nxt = '0;
            kv_set    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            count_nxt = count + 6'd1;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          blk_en = 1'b1;
          if (count == BLK_LAST) begin
            count_nxt = '0;
            if (key_valid) begin
              state_nxt = S_START;
            end else begin
              err_set   = 1'b1;
              state_nxt = S_IDLE;
            end
          end else begin
            count_nxt = count + 6'd1;
          end
        end
      end
      S_START: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    in_ready = ready_q;
    start    = (state == S_START);
    busy     = (state == S_START) || (state == S_WAIT);
  end

endmodule

// File: tb/tb_aes_byte_loader.sv
module tb_aes_byte_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         load_key;
  logic [1:0]   mode;
  logic         core_done;
  logic [255:0] key_out;
  logic [1:0]   key_mode;
  logic         key_valid;
  logic [127:0] block_out;
  logic         start;
  logic         busy;
  logic         error;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  int unsigned acc_cnt    = 0;
  int unsigned start_cnt  = 0;
  int unsigned err_cnt    = 0;

  aes_byte_loader #(.KEY_W(256), .BLK_BYTES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .load_key  (load_key),
    .mode      (mode),
    .core_done (core_done),
    .key_out   (key_out),
    .key_mode  (key_mode),
    .key_valid (key_valid),
    .block_out (block_out),
    .start     (start),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_valid === 1'b1 && in_ready === 1'b1) acc_cnt++;
    if (start === 1'b1) start_cnt++;
    if (error === 1'b1) err_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a byte and hold it until accepted (bounded), then drop in_valid.
  task automatic send_byte(input logic [7:0] b, input logic lk, input logic [1:0] m);
    int unsigned n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    load_key = lk;
    mode     = m;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("accept_timeout", 256'(n), 256'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] snap;
    int unsigned  hold_bad;
    int unsigned  s0, a0;

    reset = 1'b0; in_valid = 1'b0; in_data = '0; load_key = 1'b0;
    mode = 2'b00; core_done = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_ready", 256'(in_ready), 256'd0);
    check("rst_key", key_out, 256'd0);
    check("rst_block", 256'(block_out), 256'd0);
    check("rst_flags", 256'({key_valid, key_mode, start, busy, error}), 256'd0);
    @(negedge clk) reset = 1'b1;
    tick();
    check("post_rst_ready", 256'(in_ready), 256'd1);

    // Data frame without a key: error pulse, no start
    err_cnt = 0; start_cnt = 0;
    for (int i = 0; i < 16; i++) send_byte(8'(8'ha0 + i), 1'b0, 2'b00);
    check("nokey_err_now", 256'(error), 256'd1);
    tick();
    tick();
    check("nokey_err_once", 256'(err_cnt), 256'd1);
    check("nokey_no_start", 256'(start_cnt), 256'd0);
    check("nokey_idle", 256'({in_ready, busy, error}), 256'b100);
    check("nokey_block_kept", 256'(block_out), 256'(128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf));

    // 128-bit key
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, 2'b00);
    check("k128_key", key_out, 256'h000102030405060708090a0b0c0d0e0f);
    check("k128_valid_mode", 256'({key_valid, key_mode}), 256'b100);

    // Data block -> start one cycle after 16th byte
    start_cnt = 0;
    for (int i = 0; i < 16; i++) send_byte(8'(i * 17), 1'b0, 2'b00);
    check("blk_start_pulse", 256'({start, busy, in_ready}), 256'b110);
    check("blk_value", 256'(block_out), 256'(128'h00112233445566778899aabbccddeeff));
    tick();
    check("blk_start_gone", 256'({start, busy}), 256'b01);

    // Hold in S_WAIT for 50 cycles with in_valid asserted
    snap = block_out;
    a0 = acc_cnt;
    hold_bad = 0;
    in_valid = 1'b1; in_data = 8'h55; load_key = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (in_ready !== 1'b0 || block_out !== snap || key_out !== 256'h000102030405060708090a0b0c0d0e0f)
        hold_bad++;
    end
    check("wait_hold", 256'(hold_bad), 256'd0);
    check("wait_no_accept", 256'(acc_cnt - a0), 256'd0);
    @(negedge clk) core_done = 1'b1;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    in_valid  = 1'b0;
    check("done_ready", 256'({in_ready, busy}), 256'b10);
    check("one_start", 256'(start_cnt), 256'd1);

    // Stray core_done in idle is ignored
    err_cnt = 0;
    @(negedge clk) core_done = 1'b1;
    @(negedge clk) core_done = 1'b0;
    tick();
    check("stray_done", 256'({busy, in_ready, 8'(err_cnt)}), 256'({1'b0, 1'b1, 8'd0}));

    // Illegal mode on first key byte
    send_byte(8'h77, 1'b1, 2'b11);
    check("ill_err", 256'({error, in_ready, key_valid}), 256'b111);
    check("ill_key_kept", key_out, 256'h000102030405060708090a0b0c0d0e0f);
    tick();
    check("ill_err_gone", 256'({error, in_ready}), 256'b01);

    // 256-bit key with random gaps
    s0 = start_cnt;
    a0 = acc_cnt;
    for (int i = 0; i < 32; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_byte(8'(i), 1'b1, 2'b10);
      if (i == 30) check("k256_not_yet", 256'(key_valid), 256'd0);
    end
    check("k256_key", key_out, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    check("k256_mode_valid", 256'({key_valid, key_mode}), 256'b110);
    check("k256_accepted", 256'(acc_cnt - a0), 256'd32);
    check("k256_no_start", 256'(start_cnt - s0), 256'd0);

    // Second block reuses the held key
    for (int i = 0; i < 16; i++) send_byte(8'(8'hf0 - i), 1'b0, 2'b00);
    check("blk2_start", 256'(start), 256'd1);
    check("blk2_value", 256'(block_out), 256'(128'hf0efeeedecebeae9e8e7e6e5e4e3e2e1));
    tick();
    @(negedge clk) core_done = 1'b1;
    @(negedge clk) core_done = 1'b0;
    check("blk2_done", 256'({in_ready, busy, key_valid}), 256'b101);

    // Reset in the middle of a 192-bit key
    for (int i = 0; i < 10; i++) send_byte(8'(i), 1'b1, 2'b01);
    reset = 1'b0;
    #1;
    check("midrst_key", key_out, 256'd0);
    check("midrst_flags", 256'({in_ready, key_valid, key_mode, start, busy, error, block_out}), 256'd0);
    @(negedge clk) reset = 1'b1;
    tick();
    for (int i = 0; i < 24; i++) send_byte(8'(i), 1'b1, 2'b01);
    check("k192_key", key_out, 256'h000102030405060708090a0b0c0d0e0f1011121314151617);
    check("k192_mode_valid", 256'({key_valid, key_mode}), 256'b101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
